// File: rtl/seq_detect_param.sv
// Serial pattern detector with overlap control and optional saturating match counter.
// Define SEQ_DET_CNT_EN to add the match_cnt port and its counter.
module seq_detect_param #(
  parameter int          PAT_LEN = 5,
  parameter logic [15:0] PATTERN = 16'b0000_0000_0001_1101,
  parameter int          CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_vld,
  input  logic             clr,
  input  logic             overlap_en,
  output logic             match
`ifdef SEQ_DET_CNT_EN
  ,
  output logic [CNT_W-1:0] match_cnt
`endif
);

  localparam int FW = $clog2(PAT_LEN + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_LEN);

  if (PAT_LEN < 2 || PAT_LEN > 16 || CNT_W < 1) begin : g_bad_param
    $error("seq_detect_param: illegal PAT_LEN or CNT_W");
  end

  logic [PAT_LEN-1:0] hist;
  logic [PAT_LEN-1:0] hist_nxt;
  logic [FW-1:0]      fill;
  logic [FW-1:0]      fill_nxt;
  logic               hit;

  always_comb begin
    hist_nxt = {hist[PAT_LEN-2:0], din};
    fill_nxt = (fill == FULL) ? fill : fill + 1'b1;
    hit      = din_vld && (fill_nxt == FULL) && (hist_nxt == PATTERN[PAT_LEN-1:0]);
  end

  // A non-overlapping hit empties the fill count so none of its bits are reused.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist  <= '0;
      fill  <= '0;
      match <= 1'b0;
    end else if (clr) begin
      hist  <= '0;
      fill  <= '0;
      match <= 1'b0;
    end else begin
      match <= hit;
      if (din_vld) begin
        hist <= hist_nxt;
        fill <= (hit && !overlap_en) ? '0 : fill_nxt;
      end
    end
  end

`ifdef SEQ_DET_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_cnt <= '0;
    end else if (clr) begin
      match_cnt <= '0;
    end else if (hit && (match_cnt != {CNT_W{1'b1}})) begin
      match_cnt <= match_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: vector table, directed corner sequences and random stream vs. a queue model.
// With SEQ_DET_CNT_EN defined it also checks match_cnt, including a CNT_W=2 instance for saturation.
module tb_seq_detect_param;

  localparam int PAT_LEN = 5;

  logic clk;
  logic rst_n;
  logic din;
  logic din_vld;
  logic clr;
  logic overlap_en;
  logic match;
  logic match2;
`ifdef SEQ_DET_CNT_EN
  logic [15:0] match_cnt;
  logic [1:0]  match_cnt2;
`endif

  seq_detect_param dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .clr(clr),
    .overlap_en(overlap_en), .match(match)
`ifdef SEQ_DET_CNT_EN
    , .match_cnt(match_cnt)
`endif
  );

  seq_detect_param #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .clr(clr),
    .overlap_en(overlap_en), .match(match2)
`ifdef SEQ_DET_CNT_EN
    , .match_cnt(match_cnt2)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  int n_checks = 0;
  int n_fail   = 0;
  logic [PAT_LEN-1:0] pat;
  bit   mq[$];
  int   mcnt;
  int   mcnt2;
  logic exp_q[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mcnt  = 0;
    mcnt2 = 0;
  endtask

  // Behavioural model: last PAT_LEN accepted bits held in a queue
  task automatic model_step(input logic v, input logic d, input logic c, input logic o,
                            output logic exp);
    exp = 1'b0;
    if (c) begin
      model_reset();
    end else if (v) begin
      mq.push_back(d);
      if (mq.size() > PAT_LEN) void'(mq.pop_front());
      if (mq.size() == PAT_LEN) begin
        exp = 1'b1;
        for (int i = 0; i < PAT_LEN; i++)
          if (mq[i] != pat[PAT_LEN-1-i]) exp = 1'b0;
      end
      if (exp) begin
        mcnt  = (mcnt  < 65535) ? mcnt + 1  : mcnt;
        mcnt2 = (mcnt2 < 3)     ? mcnt2 + 1 : mcnt2;
        if (!o) mq.delete();
      end
    end
  endtask

  task automatic check_outputs(input logic exp);
    check("match", match, exp);
    check("match_p2", match2, exp);
`ifdef SEQ_DET_CNT_EN
    check("match_cnt", match_cnt, mcnt);
    check("match_cnt_w2", match_cnt2, mcnt2);
`endif
  endtask

  // driver: one clock with given inputs, then compare against the model
  task automatic apply(input logic v, input logic d, input logic c, input logic o,
                       output logic exp);
    din_vld = v; din = d; clr = c; overlap_en = o;
    @(posedge clk);
    #1;
    model_step(v, d, c, o, exp);
    exp_q.push_back(exp);
    check_outputs(exp_q.pop_front());
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n, input logic o);
    logic e;
    for (int i = n - 1; i >= 0; i--) apply(1'b1, bits[i], 1'b0, o, e);
  endtask

  task automatic do_clear();
    logic e;
    apply(1'b0, 1'b0, 1'b1, 1'b1, e);
  endtask

  typedef struct {
    logic v;
    logic d;
    logic c;
    logic o;
    logic exp_match;
    int   exp_cnt;
  } vec_t;

  vec_t vecs[$];
  logic [8:0] stream9;

  initial begin
    logic e;
    int   cnt_seq [5];
    int   det;
    logic ov;

    pat = 5'b11101;
    stream9 = 9'b111011101;
    rst_n = 1'b0; din = 1'b0; din_vld = 1'b0; clr = 1'b0; overlap_en = 1'b1;
    model_reset();
    #12;
    check("reset_match", match, 0);
`ifdef SEQ_DET_CNT_EN
    check("reset_cnt", match_cnt, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // table: 9-bit stream overlapping, clear, then non-overlapping
    for (int i = 8; i >= 0; i--)
      vecs.push_back('{1'b1, stream9[i], 1'b0, 1'b1, (i == 4 || i == 0),
                       (i > 4) ? 0 : ((i > 0) ? 1 : 2)});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0});
    for (int i = 8; i >= 0; i--)
      vecs.push_back('{1'b1, stream9[i], 1'b0, 1'b0, (i == 4), (i > 4) ? 0 : 1});
    foreach (vecs[k]) begin
      apply(vecs[k].v, vecs[k].d, vecs[k].c, vecs[k].o, e);
      check($sformatf("vec%0d_match", k), match, vecs[k].exp_match);
`ifdef SEQ_DET_CNT_EN
      check($sformatf("vec%0d_cnt", k), match_cnt, vecs[k].exp_cnt);
`endif
    end

    // gap of 10 idle cycles mid-pattern
    do_clear();
    send_bits(16'b111, 3, 1'b1);
    for (int i = 0; i < 10; i++) begin
      apply(1'b0, $urandom_range(0, 1), 1'b0, 1'b1, e);
      check("gap_match", match, 0);
    end
    send_bits(16'b01, 2, 1'b1);
    check("gap_final_match", match, 1);

    // clear wins over a simultaneous valid bit
    do_clear();
    send_bits(16'b1110, 4, 1'b1);
    apply(1'b1, 1'b1, 1'b1, 1'b1, e);
    check("clr_match", match, 0);
`ifdef SEQ_DET_CNT_EN
    check("clr_cnt", match_cnt, 0);
`endif
    send_bits(16'b11101, 5, 1'b1);
    check("after_clr_match", match, 1);

    // async reset while match is high
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_match", match, 0);
`ifdef SEQ_DET_CNT_EN
    check("async_rst_cnt", match_cnt, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // reset mid-sequence discards partial progress
    send_bits(16'b1110, 4, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("mid_rst_match", match, 0);
`ifdef SEQ_DET_CNT_EN
    check("mid_rst_cnt", match_cnt, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    send_bits(16'b1, 1, 1'b1);
    check("post_rst_match", match, 0);

    // five overlapping detections: CNT_W=2 counter saturates at 3
    do_clear();
    cnt_seq = '{1, 2, 3, 3, 3};
    send_bits(16'b11101, 5, 1'b1);
    det = 0;
`ifdef SEQ_DET_CNT_EN
    check("sat_cnt0", match_cnt2, cnt_seq[det]);
`endif
    check("sat_match0", match2, 1);
    for (det = 1; det < 5; det++) begin
      send_bits(16'b1101, 4, 1'b1);
      check($sformatf("sat_match%0d", det), match2, 1);
`ifdef SEQ_DET_CNT_EN
      check($sformatf("sat_cnt%0d", det), match_cnt2, cnt_seq[det]);
`endif
    end

    // randomized stream against the model
    ov = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 49) == 0) ov = ~ov;
      apply($urandom_range(0, 3) != 0, ($urandom_range(0, 3) != 0),
            $urandom_range(0, 99) < 2, ov, e);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
